encoder83_sync: RTL and testbench

Registered 8-to-3 priority encoder: the reverse direction of the 3-to-8 decoder. It accepts eight asynchronous request lines (buttons or switches), synchronizes and debounces them, and encodes the settled vector into a 3-bit index. The result is held stable behind a valid/ready handshake until the consumer accepts it. It sits between board-level inputs and any logic that expects a binary code, for example a decoder/display path.

---
 rtl/pdd_pkg.sv | 36 +++
 rtl/sync2.sv | 24 ++
 rtl/encoder83_sync.sv | 121 ++++++++++++
 tb/tb_encoder83_sync.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdd_pkg.sv
// Shared types and helpers for the push-button/decoder/display path:
// FSM state encoding and the 8-to-3 priority encoding function.
package pdd_pkg;

  localparam int ENC_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic [ENC_WIDTH-1:0] code;
    logic                 multi;
  } enc_t;

  // Highest set index wins; multi flags any second set bit (v & (v-1) clears the lowest one).
  function automatic enc_t prio_enc8(input logic [7:0] v);
    enc_t r;
    r.multi = ((v & (v - 8'd1)) != 8'd0);
    casez (v)
      8'b1???????: r.code = 3'd7;
      8'b01??????: r.code = 3'd6;
      8'b001?????: r.code = 3'd5;
      8'b0001????: r.code = 3'd4;
      8'b00001???: r.code = 3'd3;
      8'b000001??: r.code = 3'd2;
      8'b0000001?: r.code = 3'd1;
      default:     r.code = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer for signals asynchronous to clk.
module sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Two-stage capture; only q is safe to use downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      q      <= '0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/encoder83_sync.sv
// Debounced, registered 8-to-3 priority encoder with a valid/ready output handshake.
// A captured code is reported once; the inputs must return to zero before the next report.
module encoder83_sync
  import pdd_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in,
  input  logic                 ready,
  output logic [ENC_WIDTH-1:0] code,
  output logic                 valid,
  output logic                 multi
);

  localparam logic [7:0] DEB = DEBOUNCE[7:0];

  state_t               state_r, state_n;
  logic [7:0]           sync_s;
  logic [7:0]           snap_r, snap_n;
  logic [7:0]           cnt_r, cnt_n;
  logic [ENC_WIDTH-1:0] code_n;
  logic                 multi_n, valid_n;
  enc_t                 enc_s;

  sync2 #(.WIDTH(8)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in),
    .q     (sync_s)
  );

  // State, debounce bookkeeping and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      snap_r  <= 8'd0;
      cnt_r   <= 8'd0;
      code    <= 3'd0;
      multi   <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_r <= state_n;
      snap_r  <= snap_n;
      cnt_r   <= cnt_n;
      code    <= code_n;
      multi   <= multi_n;
      valid   <= valid_n;
    end
  end

  // Next-state logic; cnt stops at DEB because reaching it leaves SETTLE.
  always_comb begin
    state_n = state_r;
    snap_n  = snap_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (sync_s != 8'd0) begin
          state_n = ST_SETTLE;
          snap_n  = sync_s;
          cnt_n   = 8'd1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (sync_s == 8'd0) begin
          state_n = ST_IDLE;
          cnt_n   = 8'd0;
        end else if (sync_s != snap_r) begin
          snap_n = sync_s;
          cnt_n  = 8'd1;
        end else if (cnt_r == DEB) begin
          state_n = ST_HOLD;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_HOLD: begin
        if (valid && ready) begin
          state_n = ST_RELEASE;
        end else begin
          state_n = ST_HOLD;
        end
      end
      ST_RELEASE: begin
        if (sync_s == 8'd0) begin
          state_n = ST_IDLE;
          cnt_n   = 8'd0;
        end else begin
          state_n = ST_RELEASE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        snap_n  = 8'd0;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // Output logic; code and multi keep their last value once valid drops.
  always_comb begin
    enc_s   = prio_enc8(snap_r);
    code_n  = code;
    multi_n = multi;
    valid_n = valid;
    if ((state_r == ST_SETTLE) && (sync_s == snap_r) && (cnt_r == DEB)) begin
      code_n  = enc_s.code;
      multi_n = enc_s.multi;
      valid_n = 1'b1;
    end else if ((state_r == ST_HOLD) && valid && ready) begin
      valid_n = 1'b0;
    end else begin
      valid_n = valid;
    end
  end

endmodule

// File: tb/tb_encoder83_sync.sv
// Self-checking bench for encoder83_sync: directed scenarios plus randomized
// stimulus compared against a run-length reference model.
module tb_encoder83_sync;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_v = 8'd0;
  logic       ready = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic       multi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  encoder83_sync #(.DEBOUNCE(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_v),
    .ready (ready),
    .code  (code),
    .valid (valid),
    .multi (multi)
  );

  // Reference model: the encoder sees inputs two edges late and reports a value
  // once it has been seen identical and nonzero on D+1 consecutive edges.
  // Phase 0 = waiting, 1 = reported, 2 = accepted and waiting for all-zero.
  logic [7:0] sh1 = 8'd0, sh2 = 8'd0, m_last = 8'd0, n_last;
  int         m_run = 0, m_phase = 0, n_run, n_phase;
  logic       m_valid = 1'b0, m_multi = 1'b0, n_valid, n_multi;
  logic [2:0] m_code = 3'd0, n_code;

  function automatic logic [2:0] top_index(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  always_comb begin
    n_phase = m_phase;
    n_run   = m_run;
    n_last  = m_last;
    n_valid = m_valid;
    n_code  = m_code;
    n_multi = m_multi;
    if (m_phase == 0) begin
      if (sh2 == 8'd0) n_run = 0;
      else if (sh2 == m_last) n_run = m_run + 1;
      else n_run = 1;
      n_last = sh2;
      if (n_run == D + 1) begin
        n_phase = 1;
        n_valid = 1'b1;
        n_code  = top_index(sh2);
        n_multi = ($countones(sh2) > 1);
      end
    end else if (m_phase == 1) begin
      if (ready) begin
        n_phase = 2;
        n_valid = 1'b0;
      end
    end else begin
      if (sh2 == 8'd0) begin
        n_phase = 0;
        n_run   = 0;
        n_last  = 8'd0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh1 <= 8'd0; sh2 <= 8'd0; m_last <= 8'd0; m_run <= 0; m_phase <= 0;
      m_valid <= 1'b0; m_code <= 3'd0; m_multi <= 1'b0;
    end else begin
      sh1 <= in_v; sh2 <= sh1; m_last <= n_last; m_run <= n_run; m_phase <= n_phase;
      m_valid <= n_valid; m_code <= n_code; m_multi <= n_multi;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; in_v = 8'd0; ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", code); end
    checks++; if (multi !== 1'b0) begin errors++; $display("FAIL reset_multi: got %b want 0", multi); end
    rst_n = 1'b1; in_v = 8'h08;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (valid !== (e >= D + 3)) begin errors++; $display("FAIL press_valid_E%0d: got %b want %b", e, valid, (e >= D + 3)); end
      if (e >= D + 3) begin
        checks++; if (code !== 3'd3) begin errors++; $display("FAIL press_code_E%0d: got %0d want 3", e, code); end
        checks++; if (multi !== 1'b0) begin errors++; $display("FAIL press_multi_E%0d: got %b want 0", e, multi); end
      end
    end
    ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL press_accept: valid=%b want 0", valid); end
    ready = 1'b0; in_v = 8'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_multi;
    in_v = 8'h81;
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL multi_wait: valid=%b want 1", valid); end
    checks++; if (code !== 3'd7) begin errors++; $display("FAIL multi_code: got %0d want 7", code); end
    checks++; if (multi !== 1'b1) begin errors++; $display("FAIL multi_flag: got %b want 1", multi); end
    ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL multi_accept: valid=%b want 0", valid); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL multi_rereport_%0d: valid=%b want 0", i, valid); end
    end
    in_v = 8'd0; ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 4; k++) begin
      in_v = (k % 2 == 0) ? 8'h04 : 8'h00;
      repeat (2) begin
        @(posedge clk); @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bounce_valid_k%0d: got %b want 0", k, valid); end
      end
    end
    in_v = 8'h04;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (valid !== (e >= D + 3)) begin errors++; $display("FAIL bounce_settle_E%0d: valid=%b want %b", e, valid, (e >= D + 3)); end
    end
    checks++; if (code !== 3'd2) begin errors++; $display("FAIL bounce_code: got %0d want 2", code); end
    ready = 1'b1; @(negedge clk); ready = 1'b0; in_v = 8'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_settle_change;
    in_v = 8'h02;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 3) in_v = 8'h22;
      checks++;
      if (valid !== (e >= 10)) begin errors++; $display("FAIL change_valid_E%0d: got %b want %b", e, valid, (e >= 10)); end
    end
    checks++; if (code !== 3'd5) begin errors++; $display("FAIL change_code: got %0d want 5", code); end
    checks++; if (multi !== 1'b1) begin errors++; $display("FAIL change_multi: got %b want 1", multi); end
    ready = 1'b1; @(negedge clk); ready = 1'b0; in_v = 8'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_hold_release;
    in_v = 8'h02;
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd1) begin errors++; $display("FAIL hold_first: valid=%b code=%0d want 1/1", valid, code); end
    in_v = 8'h80;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b1 || code !== 3'd1) begin errors++; $display("FAIL hold_frozen_%0d: valid=%b code=%0d want 1/1", i, valid, code); end
    end
    ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_accept: valid=%b want 0", valid); end
    ready = 1'b0; in_v = 8'd0;
    repeat (4) @(negedge clk);
    in_v = 8'h80;
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd7) begin errors++; $display("FAIL hold_second: valid=%b code=%0d want 1/7", valid, code); end
    checks++; if (multi !== 1'b0) begin errors++; $display("FAIL hold_second_multi: got %b want 0", multi); end
    ready = 1'b1; @(negedge clk); ready = 1'b0; in_v = 8'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset;
    in_v = 8'h30;
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd5 || multi !== 1'b1) begin errors++; $display("FAIL areset_pre: valid=%b code=%0d multi=%b want 1/5/1", valid, code, multi); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", valid); end
    checks++; if (code !== 3'd0) begin errors++; $display("FAIL areset_code: got %0d want 0", code); end
    checks++; if (multi !== 1'b0) begin errors++; $display("FAIL areset_multi: got %b want 0", multi); end
    @(negedge clk);
    rst_n = 1'b1; in_v = 8'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random;
    int r;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (valid !== m_valid || code !== m_code || multi !== m_multi) begin
        errors++;
        $display("FAIL random_c%0d: valid/code/multi=%b/%0d/%b want %b/%0d/%b", c, valid, code, multi, m_valid, m_code, m_multi);
      end
      r = $urandom_range(0, 99);
      if (r < 6) in_v = 8'($urandom);
      else if (r < 10) in_v = 8'(1 << $urandom_range(0, 7));
      else if (r < 16) in_v = 8'd0;
      else in_v = in_v;
      ready = ($urandom_range(0, 3) == 0);
    end
    in_v = 8'd0; ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_multi();
    test_bounce();
    test_settle_change();
    test_hold_release();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
